// File: rtl/cache_pkg.sv
// Shared cache-block types: replacement request opcodes, LRU tracker state, width helpers.
package cache_pkg;

  typedef enum logic {
    LRU_HIT  = 1'b0,
    LRU_FILL = 1'b1
  } lru_op_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } lru_state_e;

  // Index width that never collapses to zero bits, for blocks sized by small counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational true-LRU row update: pick the victim for FILL, promote the touched way to MRU
// and age every way that was younger than it.
module lru_age_update
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] i_row,
  input  lru_op_e                    i_op,
  input  logic [AGE_W-1:0]           i_way,
  output logic [WAYS-1:0][AGE_W-1:0] o_row,
  output logic [AGE_W-1:0]           o_way,
  output logic                       o_err
);

  localparam logic [AGE_W-1:0] MRU_AGE = AGE_W'(WAYS - 1);

  logic [AGE_W-1:0] w_victim;
  logic [AGE_W-1:0] w_target;
  logic [AGE_W-1:0] w_old_age;
  logic             w_err;

  // Lowest-numbered way with age 0; way 0 when the row holds no zero age.
  always_comb begin
    w_victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_row[w] == '0) w_victim = AGE_W'(w);
    end
  end

  assign w_err    = (i_op == LRU_HIT) && ({1'b0, i_way} >= (AGE_W + 1)'(WAYS));
  assign w_target = (i_op == LRU_FILL) ? w_victim : i_way;

  always_comb begin
    w_old_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_target == AGE_W'(w)) w_old_age = i_row[w];
    end
  end

  always_comb begin
    o_row = i_row;
    if (!w_err) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_target == AGE_W'(w)) o_row[w] = MRU_AGE;
        else if (i_row[w] > w_old_age) o_row[w] = i_row[w] - AGE_W'(1);
      end
    end
  end

  assign o_way = w_target;
  assign o_err = w_err;

endmodule

// File: rtl/lru_age_tracker.sv
// Per-set true-LRU age store: reset-time init sweep, registered row read, one-stage update
// with same-set forwarding, responses two cycles after acceptance.
module lru_age_tracker
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int AGE_W = $clog2(WAYS),
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic             acc_op,
  input  logic [IDX_W-1:0] acc_set,
  input  logic [AGE_W-1:0] acc_way,
  output logic             resp_valid,
  output logic [AGE_W-1:0] resp_way,
  output logic             resp_err
);

  typedef logic [WAYS-1:0][AGE_W-1:0] row_t;

  lru_state_e       r_state;
  logic [IDX_W-1:0] r_sweep;
  logic             r_ready;

  row_t             r_ages [SETS];

  logic             r_vld_p1;
  lru_op_e          r_op_p1;
  logic [IDX_W-1:0] r_set_p1;
  logic [AGE_W-1:0] r_way_p1;

  logic             r_vld_p2;
  lru_op_e          r_op_p2;
  logic [IDX_W-1:0] r_set_p2;
  logic [AGE_W-1:0] r_way_p2;
  row_t             r_row_p2;

  logic             r_resp_vld;
  logic [AGE_W-1:0] r_resp_way;
  logic             r_resp_err;

  row_t             w_init_row;
  row_t             w_new_row;
  logic [AGE_W-1:0] w_touch_way;
  logic             w_err;
  logic             w_accept;
  logic             w_write;
  logic             w_fwd;

  always_comb begin
    w_init_row = '0;
    for (int w = 0; w < WAYS; w++) w_init_row[w] = AGE_W'(w);
  end

  assign w_accept = acc_valid && r_ready;
  assign w_write  = r_vld_p2 && !w_err;
  assign w_fwd    = w_write && (r_set_p2 == r_set_p1);

  lru_age_update #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_update (
    .i_row (r_row_p2),
    .i_op  (r_op_p2),
    .i_way (r_way_p2),
    .o_row (w_new_row),
    .o_way (w_touch_way),
    .o_err (w_err)
  );

  // Row storage: the sweep owns the array in INIT, the update stage owns it in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) r_ages[r_sweep] <= w_init_row;
      else if (w_write) r_ages[r_set_p2] <= w_new_row;
    end
  end

  // p1: request capture
  always_ff @(posedge clk) begin
    r_op_p1  <= lru_op_e'(acc_op);
    r_set_p1 <= acc_set;
    r_way_p1 <= acc_way;
  end

  // p2: registered row read, overridden by the row being written this same edge
  always_ff @(posedge clk) begin
    r_op_p2  <= r_op_p1;
    r_set_p2 <= r_set_p1;
    r_way_p2 <= r_way_p1;
    r_row_p2 <= w_fwd ? w_new_row : r_ages[r_set_p1];
  end

  // Control: FSM, sweep counter, valid pipeline and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_sweep    <= '0;
      r_ready    <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_resp_vld <= 1'b0;
      r_resp_way <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_sweep <= r_sweep + IDX_W'(1);
        if (r_sweep == IDX_W'(SETS - 1)) begin
          r_state <= RUN;
          r_ready <= 1'b1;
        end
      end
      r_vld_p1   <= w_accept;
      r_vld_p2   <= r_vld_p1;
      r_resp_vld <= r_vld_p2;
      if (r_vld_p2) begin
        r_resp_way <= w_touch_way;
        r_resp_err <= w_err;
      end
    end
  end

  assign acc_ready  = r_ready;
  assign resp_valid = r_resp_vld;
  assign resp_way   = r_resp_way;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lru_age_tracker.sv
// Bench for lru_age_tracker: directed cases plus randomized HIT/FILL traffic against an
// age-list reference model; a small WAYS=3 instance covers the out-of-range HIT error.
module tb_lru_age_tracker;

  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int AGE_W = 2;
  localparam int IDX_W = 4;
  localparam int BWAYS = 3;
  localparam int BSETS = 2;
  localparam int BAGE  = 2;
  localparam int BIDX  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             acc_valid = 1'b0;
  logic             acc_op = 1'b0;
  logic [IDX_W-1:0] acc_set = '0;
  logic [AGE_W-1:0] acc_way = '0;
  logic             acc_ready;
  logic             resp_valid;
  logic [AGE_W-1:0] resp_way;
  logic             resp_err;

  logic             b_rst = 1'b1;
  logic             b_valid = 1'b0;
  logic             b_op = 1'b0;
  logic [BIDX-1:0]  b_set = '0;
  logic [BAGE-1:0]  b_way = '0;
  logic             b_ready;
  logic             b_resp_valid;
  logic [BAGE-1:0]  b_resp_way;
  logic             b_resp_err;

  lru_age_tracker #(.WAYS(WAYS), .SETS(SETS)) u_dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_op(acc_op),
    .acc_set(acc_set), .acc_way(acc_way), .resp_valid(resp_valid), .resp_way(resp_way),
    .resp_err(resp_err)
  );

  lru_age_tracker #(.WAYS(BWAYS), .SETS(BSETS)) u_dut3 (
    .clk(clk), .rst(b_rst), .acc_valid(b_valid), .acc_ready(b_ready), .acc_op(b_op),
    .acc_set(b_set), .acc_way(b_way), .resp_valid(b_resp_valid), .resp_way(b_resp_way),
    .resp_err(b_resp_err)
  );

  int total = 0;
  int bad   = 0;

  int m_age [SETS][WAYS];
  bit m_ready = 0;
  int d1_v = 0, d1_way = 0, d2_v = 0, d2_way = 0;
  bit capture = 0;
  int got_way [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_age[s][w] = w;
  endfunction

  // Touch semantics: younger-than-touched ways age by one, touched way becomes MRU.
  function automatic int model_access(input int op, input int set, input int way);
    int k;
    int a;
    k = 0;
    if (op == 1) begin
      for (int w = WAYS - 1; w >= 0; w--) if (m_age[set][w] == 0) k = w;
    end else begin
      k = way;
    end
    a = m_age[set][k];
    for (int w = 0; w < WAYS; w++) if (m_age[set][w] > a) m_age[set][w] = m_age[set][w] - 1;
    m_age[set][k] = WAYS - 1;
    return k;
  endfunction

  task automatic clear_pipe();
    d1_v = 0; d1_way = 0; d2_v = 0; d2_way = 0;
  endtask

  task automatic step(input bit v, input bit op, input int set, input int way);
    bit acc;
    int ev;
    int ew;
    @(negedge clk);
    acc_valid = v;
    acc_op    = op;
    acc_set   = IDX_W'(set);
    acc_way   = AGE_W'(way);
    if (v) check_eq("acc_ready", acc_ready, m_ready);
    acc = v && m_ready;
    @(posedge clk);
    ev = d2_v; ew = d2_way;
    d2_v = d1_v; d2_way = d1_way;
    d1_v = acc;
    d1_way = acc ? model_access(op, set, way) : 0;
    #1;
    check_eq("resp_valid", resp_valid, ev);
    if (ev != 0) begin
      check_eq("resp_way", resp_way, ew);
      check_eq("resp_err", resp_err, 0);
      if (capture) got_way.push_back(int'(resp_way));
    end
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    acc_valid = 1'b0;
    repeat (n) @(negedge clk);
    check_eq("rst_ready", acc_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_way", resp_way, 0);
    check_eq("rst_resp_err", resp_err, 0);
    m_ready = 0;
    clear_pipe();
  endtask

  task automatic release_and_sweep(input string tag);
    int n;
    bit spurious;
    n = 0;
    spurious = 0;
    @(negedge clk);
    rst = 1'b0;
    while (!acc_ready && n < 100) begin
      n++;
      if (resp_valid) spurious = 1;
      @(negedge clk);
    end
    check_eq({tag, "_ready_low_cycles"}, n, SETS);
    check_eq({tag, "_no_resp_in_sweep"}, spurious, 0);
    model_init();
    m_ready = 1;
    clear_pipe();
  endtask

  task automatic b_req(input bit op, input int way, input int exp_way, input int exp_err,
                       input string tag);
    @(negedge clk);
    b_valid = 1'b1; b_op = op; b_set = '0; b_way = BAGE'(way);
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_early"}, b_resp_valid, 0);
    @(negedge clk);
    check_eq({tag, "_valid"}, b_resp_valid, 1);
    check_eq({tag, "_way"}, b_resp_way, exp_way);
    check_eq({tag, "_err"}, b_resp_err, exp_err);
    @(negedge clk);
    check_eq({tag, "_pulse"}, b_resp_valid, 0);
  endtask

  initial begin
    int n;
    int exp_dir [8];
    int mask;
    int op;
    int set;
    exp_dir = '{0, 1, 0, 2, 0, 1, 3, 0};

    // WAYS=3 instance: sweep length, out-of-range HIT, and the row it must leave alone.
    repeat (3) @(negedge clk);
    check_eq("b_rst_ready", b_ready, 0);
    b_rst = 1'b0;
    n = 0;
    while (!b_ready && n < 50) begin n++; @(negedge clk); end
    check_eq("b_ready_low_cycles", n, BSETS);
    b_req(1'b0, 3, 3, 1, "b_hit_err");
    b_req(1'b1, 0, 0, 0, "b_fill_after_err");
    b_req(1'b0, 0, 0, 0, "b_hit0");
    b_req(1'b1, 0, 1, 0, "b_fill_next");

    hold_reset(2);
    release_and_sweep("init");

    capture = 1;
    got_way.delete();
    step(1, 1, 3, 0);
    step(1, 0, 5, 1);
    step(1, 1, 5, 0);
    step(1, 1, 5, 0);
    step(1, 0, 7, 0);
    step(1, 1, 7, 0);
    step(1, 0, 2, 3);
    step(1, 1, 2, 0);
    repeat (3) step(0, 0, 0, 0);
    capture = 0;
    check_eq("dir_count", got_way.size(), 8);
    for (int i = 0; i < 8 && i < got_way.size(); i++) check_eq("dir_way", got_way[i], exp_dir[i]);

    // Reset at sweep set 9: sweep must restart from set 0.
    hold_reset(1);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("mid_sweep_ready", acc_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_sweep_rst_ready", acc_ready, 0);
    release_and_sweep("resweep");

    // Reset while a request sits in the update stage: its response is dropped.
    step(1, 0, 4, 2);
    @(negedge clk);
    acc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("drop_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    check_eq("drop_resp_valid2", resp_valid, 0);
    m_ready = 0;
    clear_pipe();
    release_and_sweep("after_drop");

    for (int i = 0; i < 10000; i++) begin
      op  = $urandom_range(0, 1);
      set = ($urandom_range(0, 3) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 1);
      step($urandom_range(0, 9) < 8, op[0], set, $urandom_range(0, WAYS - 1));
    end
    repeat (3) step(0, 0, 0, 0);

    for (int s = 0; s < SETS; s++) begin
      mask = 0;
      for (int w = 0; w < WAYS; w++) begin
        check_eq("final_age", u_dut.r_ages[s][w], m_age[s][w]);
        mask = mask | (1 << int'(u_dut.r_ages[s][w]));
      end
      check_eq("final_perm", mask, (1 << WAYS) - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
